// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
// Holds the response-slot state encoding, dcache width codes, cause codes and the width decode.
package lsu_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HELD  = 2'd2
    } lsu_state_e;

    localparam logic [2:0] W_B = 3'd1;
    localparam logic [2:0] W_H = 3'd2;
    localparam logic [2:0] W_W = 3'd4;

    localparam int CAUSE_ILLEGAL_DEF     = 2;
    localparam int CAUSE_LD_MISALIGN_DEF = 4;
    localparam int CAUSE_ST_MISALIGN_DEF = 6;

    // funct3[1:0]==2'b11 is illegal for every op; it maps to a word so the alignment check stays defined.
    function automatic logic [2:0] decode_width(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   decode_width = W_B;
            2'b01:   decode_width = W_H;
            default: decode_width = W_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational funct3 / alignment decode for one load or store.
// Illegal funct3 takes priority over misalignment when choosing the cause.
module lsu_decode
    import lsu_pkg::*;
#(
    parameter int CAUSE_LD_MISALIGN = CAUSE_LD_MISALIGN_DEF,
    parameter int CAUSE_ST_MISALIGN = CAUSE_ST_MISALIGN_DEF,
    parameter int CAUSE_ILLEGAL     = CAUSE_ILLEGAL_DEF
) (
    input  logic       load,
    input  logic       store,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic [2:0] width,
    output logic       sign,
    output logic       exc,
    output logic [3:0] cause
);

    logic illegal;
    logic misaligned;

    always_comb begin
        width   = decode_width(funct3);
        sign    = ~funct3[2];
        illegal = 1'b0;
        if (load) begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end else if (store) begin
            illegal = (funct3 >= 3'd3);
        end
        misaligned = ((width == W_H) && addr_lo[0]) ||
                     ((width == W_W) && (addr_lo != 2'b00));
        exc = (load | store) & (illegal | misaligned);
        if (illegal) begin
            cause = 4'(CAUSE_ILLEGAL);
        end else if (load) begin
            cause = 4'(CAUSE_LD_MISALIGN);
        end else begin
            cause = 4'(CAUSE_ST_MISALIGN);
        end
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage between EX and the dcache: issues one access per accepted op and
// holds a single response slot towards writeback with a ready/valid handshake.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN              = 32,
    parameter int CAUSE_LD_MISALIGN = CAUSE_LD_MISALIGN_DEF,
    parameter int CAUSE_ST_MISALIGN = CAUSE_ST_MISALIGN_DEF,
    parameter int CAUSE_ILLEGAL     = CAUSE_ILLEGAL_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_load,
    input  logic            ex_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            kill,
    output logic            dc_ren,
    output logic            dc_wen,
    output logic [XLEN-1:0] dc_addr,
    output logic [2:0]      dc_rwidth,
    output logic            dc_rsign,
    output logic [2:0]      dc_wwidth,
    output logic [XLEN-1:0] dc_wdata,
    output logic            dc_pipeline_en,
    input  logic            dc_valid,
    input  logic [XLEN-1:0] dc_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic            wb_is_load,
    output logic [XLEN-1:0] wb_rdata,
    output logic            wb_exc,
    output logic [3:0]      wb_cause,
    output logic [XLEN-1:0] wb_badaddr,
    output logic [XLEN-1:0] wb_pc
);

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_FULL  = FULL;
    localparam logic [1:0] ST_HELD  = HELD;

    logic [2:0]      dec_width;
    logic            dec_sign;
    logic            dec_exc;
    logic [3:0]      dec_cause;
    logic            mem_op;
    logic            slot_free;
    logic            accept;
    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic            is_load_q;
    logic            exc_q;
    logic [3:0]      cause_q;
    logic [XLEN-1:0] badaddr_q;
    logic [XLEN-1:0] hold_q;

    lsu_decode #(
        .CAUSE_LD_MISALIGN (CAUSE_LD_MISALIGN),
        .CAUSE_ST_MISALIGN (CAUSE_ST_MISALIGN),
        .CAUSE_ILLEGAL     (CAUSE_ILLEGAL)
    ) u_decode (
        .load    (ex_load),
        .store   (ex_store),
        .funct3  (ex_funct3),
        .addr_lo (ex_addr[1:0]),
        .width   (dec_width),
        .sign    (dec_sign),
        .exc     (dec_exc),
        .cause   (dec_cause)
    );

    // Stage p0: request decode and issue handshake
    assign mem_op    = ex_valid & (ex_load | ex_store) & ~dec_exc & ~kill;
    assign slot_free = (state_q == ST_EMPTY) | wb_ready;
    assign ex_ready  = slot_free & (~mem_op | dc_valid);
    assign accept    = ex_valid & ex_ready & ~kill;

    assign dc_ren         = accept & mem_op & ex_load;
    assign dc_wen         = accept & mem_op & ex_store;
    assign dc_pipeline_en = accept;
    assign dc_addr        = ex_addr;
    assign dc_rwidth      = dec_width;
    assign dc_wwidth      = dec_width;
    assign dc_rsign       = dec_sign;
    assign dc_wdata       = ex_wdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  state_d = wb_ready ? (accept ? ST_FULL : ST_EMPTY) : ST_HELD;
            ST_HELD:  if (wb_ready) state_d = accept ? ST_FULL : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (kill) state_d = ST_EMPTY;
    end

    // Stage p1: response slot
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            rd_q      <= '0;
            pc_q      <= '0;
            is_load_q <= 1'b0;
            exc_q     <= 1'b0;
            cause_q   <= '0;
            badaddr_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q      <= ex_rd;
                pc_q      <= ex_pc;
                is_load_q <= ex_load & mem_op;
                exc_q     <= dec_exc;
                cause_q   <= dec_cause;
                badaddr_q <= ex_addr;
            end
            // dc_rdata is only valid the cycle after the latch, so a stalled load keeps its own copy.
            if (kill) begin
                hold_q <= '0;
            end else if ((state_q == ST_FULL) && !wb_ready) begin
                hold_q <= is_load_q ? dc_rdata : '0;
            end
        end
    end

    assign wb_valid   = (state_q != ST_EMPTY);
    assign wb_rd      = rd_q;
    assign wb_pc      = pc_q;
    assign wb_is_load = is_load_q & wb_valid;
    assign wb_exc     = exc_q & wb_valid;
    assign wb_cause   = cause_q;
    assign wb_badaddr = badaddr_q;
    assign wb_rdata   = (state_q == ST_HELD) ? hold_q :
                        (((state_q == ST_FULL) && is_load_q) ? dc_rdata : '0);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a one-cycle-latency dcache model.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata, ex_pc;
    logic [4:0]  ex_rd;
    logic        kill;
    logic        dc_ren, dc_wen, dc_rsign, dc_pipeline_en, dc_valid;
    logic [31:0] dc_addr, dc_wdata;
    logic [2:0]  dc_rwidth, dc_wwidth;
    logic [31:0] dc_rdata = 32'h0;
    logic        wb_valid, wb_ready, wb_is_load, wb_exc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rdata, wb_badaddr, wb_pc;
    logic [3:0]  wb_cause;

    logic [31:0] mem_word = 32'h0;
    int          ren_cnt = 0;
    int          wen_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    lsu_mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_pc(ex_pc),
        .kill(kill),
        .dc_ren(dc_ren), .dc_wen(dc_wen), .dc_addr(dc_addr), .dc_rwidth(dc_rwidth), .dc_rsign(dc_rsign),
        .dc_wwidth(dc_wwidth), .dc_wdata(dc_wdata), .dc_pipeline_en(dc_pipeline_en),
        .dc_valid(dc_valid), .dc_rdata(dc_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_is_load(wb_is_load),
        .wb_rdata(wb_rdata), .wb_exc(wb_exc), .wb_cause(wb_cause), .wb_badaddr(wb_badaddr), .wb_pc(wb_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [2:0] width, input logic sign);
        logic [31:0] s;
        s = w >> {lo, 3'b000};
        case (width)
            3'd1:    model_read = sign ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            3'd2:    model_read = sign ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            default: model_read = w;
        endcase
    endfunction

    // dcache: data the cycle after latch, junk otherwise so a stalled slot must use its own copy
    always @(posedge clk) begin
        if (dc_ren && dc_pipeline_en) dc_rdata <= model_read(mem_word, dc_addr[1:0], dc_rwidth, dc_rsign);
        else dc_rdata <= 32'hBAD0BAD0;
        if (dc_ren) ren_cnt <= ren_cnt + 1;
        if (dc_wen) wen_cnt <= wen_cnt + 1;
    end

    task automatic op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_addr = a; ex_wdata = wd; ex_rd = rd; ex_pc = pc;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'd0;
        ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0; ex_pc = 32'h0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        idle(); kill = 1'b0; wb_ready = 1'b1; dc_valid = 1'b1;
        step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); kill = 1'b0; wb_ready = 1'b0; dc_valid = 1'b1;
        step(); step();
        rst = 1'b0; #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", wb_valid); end
        checks++; if (wb_exc !== 1'b0) begin errors++; $display("FAIL rst_exc got %0h exp 0", wb_exc); end
        checks++; if (wb_is_load !== 1'b0) begin errors++; $display("FAIL rst_is_load got %0h exp 0", wb_is_load); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0h exp 0", wb_rd); end
        checks++; if (wb_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", wb_rdata); end
    endtask

    task automatic test_lw();
        int base;
        drain();
        mem_word = 32'hDEADBEEF; base = ren_cnt;
        op(1, 0, 3'd2, 32'h1000, 32'h0, 5'd5, 32'h100); #1;
        checks++; if (dc_ren !== 1'b1) begin errors++; $display("FAIL lw_ren got %0h exp 1", dc_ren); end
        checks++; if (dc_rwidth !== 3'd4) begin errors++; $display("FAIL lw_rwidth got %0h exp 4", dc_rwidth); end
        step(); idle(); #1;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got %0h exp 1", wb_valid); end
        checks++; if (wb_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", wb_rdata); end
        checks++; if (wb_exc !== 1'b0) begin errors++; $display("FAIL lw_exc got %0h exp 0", wb_exc); end
        checks++; if (wb_rd !== 5'd5 || wb_pc !== 32'h100) begin errors++; $display("FAIL lw_rd_pc got %0h/%h exp 5/00000100", wb_rd, wb_pc); end
        checks++; if (ren_cnt - base !== 1) begin errors++; $display("FAIL lw_ren_count got %0d exp 1", ren_cnt - base); end
    endtask

    task automatic test_lb_lbu();
        drain();
        mem_word = 32'h80000000;
        op(1, 0, 3'd0, 32'h1003, 32'h0, 5'd6, 32'h104); #1;
        checks++; if (dc_rsign !== 1'b1 || dc_rwidth !== 3'd1) begin errors++; $display("FAIL lb_ctl got sign %0h width %0h exp 1/1", dc_rsign, dc_rwidth); end
        step();
        op(1, 0, 3'd4, 32'h1003, 32'h0, 5'd7, 32'h108); #1;
        checks++; if (wb_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", wb_rdata); end
        checks++; if (dc_rsign !== 1'b0 || dc_ren !== 1'b1) begin errors++; $display("FAIL lbu_ctl got sign %0h ren %0h exp 0/1", dc_rsign, dc_ren); end
        step(); idle(); #1;
        checks++; if (wb_rdata !== 32'h00000080 || wb_rd !== 5'd7) begin errors++; $display("FAIL lbu_rdata got %h rd %0h exp 00000080 rd 7", wb_rdata, wb_rd); end
    endtask

    task automatic test_misaligned();
        drain();
        op(0, 1, 3'd1, 32'h2001, 32'h1234, 5'd0, 32'h200); #1;
        checks++; if (dc_wen !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL sh_mis_wen got wen %0h ready %0h exp 0/1", dc_wen, ex_ready); end
        step();
        op(1, 0, 3'd3, 32'h2000, 32'h0, 5'd3, 32'h204); #1;
        checks++; if (wb_exc !== 1'b1 || wb_cause !== 4'd6) begin errors++; $display("FAIL sh_mis_cause got exc %0h cause %0d exp 1/6", wb_exc, wb_cause); end
        checks++; if (wb_badaddr !== 32'h2001 || wb_is_load !== 1'b0) begin errors++; $display("FAIL sh_mis_badaddr got %h load %0h exp 00002001/0", wb_badaddr, wb_is_load); end
        checks++; if (dc_ren !== 1'b0) begin errors++; $display("FAIL ill_ren got %0h exp 0", dc_ren); end
        step(); idle(); #1;
        checks++; if (wb_exc !== 1'b1 || wb_cause !== 4'd2) begin errors++; $display("FAIL ill_cause got exc %0h cause %0d exp 1/2", wb_exc, wb_cause); end
        checks++; if (wb_rdata !== 32'h0) begin errors++; $display("FAIL ill_rdata got %h exp 0", wb_rdata); end
    endtask

    task automatic test_nonmem();
        drain();
        dc_valid = 1'b0;
        op(0, 0, 3'd2, 32'h3, 32'h0, 5'd9, 32'h300); #1;
        checks++; if (ex_ready !== 1'b1 || dc_pipeline_en !== 1'b1 || dc_ren !== 1'b0 || dc_wen !== 1'b0) begin
            errors++; $display("FAIL nonmem_issue got ready %0h pe %0h ren %0h wen %0h exp 1/1/0/0", ex_ready, dc_pipeline_en, dc_ren, dc_wen);
        end
        step(); idle(); #1;
        checks++; if (wb_valid !== 1'b1 || wb_is_load !== 1'b0 || wb_exc !== 1'b0 || wb_rd !== 5'd9) begin
            errors++; $display("FAIL nonmem_slot got v %0h ld %0h exc %0h rd %0h exp 1/0/0/9", wb_valid, wb_is_load, wb_exc, wb_rd);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        drain();
        base = ren_cnt;
        mem_word = 32'h11112222;
        op(1, 0, 3'd2, 32'h1000, 32'h0, 5'd7, 32'h400);
        step();
        wb_ready = 1'b0;
        op(1, 0, 3'd2, 32'h1004, 32'h0, 5'd8, 32'h404); #1;
        checks++; if (ex_ready !== 1'b0 || dc_ren !== 1'b0) begin errors++; $display("FAIL stall_full got ready %0h ren %0h exp 0/0", ex_ready, dc_ren); end
        checks++; if (wb_rdata !== 32'h11112222) begin errors++; $display("FAIL stall_full_rdata got %h exp 11112222", wb_rdata); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ex_ready !== 1'b0 || wb_valid !== 1'b1 || wb_rdata !== 32'h11112222) begin
                errors++; $display("FAIL stall_held_%0d got ready %0h valid %0h rdata %h exp 0/1/11112222", i, ex_ready, wb_valid, wb_rdata);
            end
        end
        mem_word = 32'h12345678; wb_ready = 1'b1; #1;
        checks++; if (ex_ready !== 1'b1 || dc_ren !== 1'b1) begin errors++; $display("FAIL stall_release got ready %0h ren %0h exp 1/1", ex_ready, dc_ren); end
        step(); idle(); #1;
        checks++; if (wb_rd !== 5'd8 || wb_rdata !== 32'h12345678) begin errors++; $display("FAIL stall_second got rd %0h rdata %h exp 8/12345678", wb_rd, wb_rdata); end
        checks++; if (ren_cnt - base !== 2) begin errors++; $display("FAIL stall_ren_count got %0d exp 2", ren_cnt - base); end
    endtask

    task automatic test_dc_stall();
        int base;
        drain();
        base = wen_cnt;
        dc_valid = 1'b0;
        op(0, 1, 3'd2, 32'h3000, 32'hCAFEF00D, 5'd0, 32'h500);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (ex_ready !== 1'b0 || dc_wen !== 1'b0) begin errors++; $display("FAIL dcstall_%0d got ready %0h wen %0h exp 0/0", i, ex_ready, dc_wen); end
            step();
        end
        dc_valid = 1'b1; #1;
        checks++; if (dc_wen !== 1'b1 || dc_wwidth !== 3'd4 || dc_wdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL dcstall_issue got wen %0h width %0h wdata %h exp 1/4/cafef00d", dc_wen, dc_wwidth, dc_wdata);
        end
        step(); idle(); #1;
        checks++; if (wen_cnt - base !== 1 || wb_valid !== 1'b1 || wb_exc !== 1'b0) begin
            errors++; $display("FAIL dcstall_done got wens %0d valid %0h exc %0h exp 1/1/0", wen_cnt - base, wb_valid, wb_exc);
        end
    endtask

    task automatic test_kill_rst();
        int base;
        drain();
        wb_ready = 1'b0;
        mem_word = 32'h55667788;
        op(1, 0, 3'd2, 32'h1000, 32'h0, 5'd9, 32'h600);
        step(); idle(); step();
        base = ren_cnt;
        op(1, 0, 3'd2, 32'h1008, 32'h0, 5'd10, 32'h604);
        kill = 1'b1; wb_ready = 1'b1; #1;
        checks++; if (dc_ren !== 1'b0 || dc_pipeline_en !== 1'b0) begin errors++; $display("FAIL kill_issue got ren %0h pe %0h exp 0/0", dc_ren, dc_pipeline_en); end
        step(); kill = 1'b0; idle(); wb_ready = 1'b0; #1;
        checks++; if (wb_valid !== 1'b0 || wb_rdata !== 32'h0) begin errors++; $display("FAIL kill_slot got valid %0h rdata %h exp 0/0", wb_valid, wb_rdata); end
        checks++; if (ren_cnt - base !== 0) begin errors++; $display("FAIL kill_ren_count got %0d exp 0", ren_cnt - base); end
        op(1, 0, 3'd2, 32'h1000, 32'h0, 5'd11, 32'h608);
        step(); idle(); #1;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0h exp 1", wb_valid); end
        rst = 1'b1;
        step(); rst = 1'b0; #1;
        checks++; if (wb_valid !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("FAIL rst_full got valid %0h rd %0h exp 0/0", wb_valid, wb_rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_misaligned();
        test_nonmem();
        test_back_to_back();
        test_dc_stall();
        test_kill_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
